// File: rtl/fifo_pkg.sv
// Shared widths and word/lane types for the FIFO read-side datapath.
package fifo_pkg;

  localparam int FIFO_IN_WIDTH  = 64;
  localparam int FIFO_OUT_WIDTH = 16;

  typedef logic [FIFO_IN_WIDTH-1:0]  word_t;
  typedef logic [FIFO_OUT_WIDTH-1:0] lane_t;

endpackage

// File: rtl/fifo_unpacker.sv
// Pops wide words from a first-word-fall-through FIFO and streams them out
// as LSB-first lanes on valid/ready, flagging the last lane of each frame.
module fifo_unpacker
  import fifo_pkg::*;
#(
  parameter int IN_WIDTH    = FIFO_IN_WIDTH,
  parameter int OUT_WIDTH   = FIFO_OUT_WIDTH,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fifo_empty,
  input  logic [IN_WIDTH-1:0]    fifo_data,
  output logic                   fifo_r_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_last,
  input  logic [FRAME_CNT_W-1:0] cfg_frame_words,
  output logic                   busy
);

  localparam int LANES = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]             state_q;
  logic [IN_WIDTH-1:0]    data_q;
  logic [IDX_W-1:0]       lane_idx_q;
  logic [FRAME_CNT_W-1:0] word_cnt_q;
  logic [FRAME_CNT_W-1:0] frame_len_q;

  logic                   lane_xfer;
  logic                   at_last_lane;
  logic                   word_done;
  logic                   frame_end;
  logic                   pop;
  logic [FRAME_CNT_W-1:0] cfg_len;

  assign out_valid    = (state_q == ST_HOLD);
  assign lane_xfer    = out_valid && out_ready;
  assign at_last_lane = (lane_idx_q == LAST_IDX);
  assign word_done    = lane_xfer && at_last_lane;
  assign frame_end    = (word_cnt_q == frame_len_q - FRAME_CNT_W'(1));
  // Refill in the same cycle the last lane leaves, so lanes stream without a bubble.
  assign pop          = !fifo_empty && ((state_q == ST_EMPTY) || word_done);
  assign fifo_r_ready = pop;
  assign out_last     = out_valid && at_last_lane && frame_end;
  assign busy         = out_valid || (word_cnt_q != '0);
  assign cfg_len      = (cfg_frame_words == '0) ? FRAME_CNT_W'(1) : cfg_frame_words;

  always_comb begin
    out_data = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (lane_idx_q == IDX_W'(k)) out_data = data_q[k*OUT_WIDTH +: OUT_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      data_q      <= '0;
      lane_idx_q  <= '0;
      word_cnt_q  <= '0;
      frame_len_q <= FRAME_CNT_W'(1);
    end else begin
      if (pop) begin
        data_q     <= fifo_data;
        lane_idx_q <= '0;
        state_q    <= ST_HOLD;
        if (word_cnt_q == '0) frame_len_q <= cfg_len;
      end else if (word_done) begin
        state_q <= ST_EMPTY;
      end else if (lane_xfer) begin
        lane_idx_q <= lane_idx_q + IDX_W'(1);
      end
      if (word_done) begin
        word_cnt_q <= frame_end ? '0 : word_cnt_q + FRAME_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_unpacker.sv
// Scoreboard bench: a depth-4 FWFT FIFO model feeds fifo_unpacker; lanes are
// predicted at push time and matched against observed transfers.
module tb_fifo_unpacker;
  import fifo_pkg::*;

  localparam int CW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          fifo_empty = 1'b1;
  word_t         fifo_data = '0;
  logic          fifo_r_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  lane_t         out_data;
  logic          out_last;
  logic [CW-1:0] cfg = 16'd1;
  logic          busy;

  always #5 clk = ~clk;

  fifo_unpacker #(
    .IN_WIDTH   (64),
    .OUT_WIDTH  (16),
    .FRAME_CNT_W(CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo_empty     (fifo_empty),
    .fifo_data      (fifo_data),
    .fifo_r_ready   (fifo_r_ready),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .cfg_frame_words(cfg),
    .busy           (busy)
  );

  typedef struct { lane_t data; logic last; } exp_t;
  typedef struct { lane_t data; logic last; logic popped; int cyc; } obs_t;

  word_t fifo_q[$];
  exp_t  exp_q[$];
  obs_t  obs_q[$];
  int    cycle  = 0;
  int    checks = 0;
  int    errors = 0;
  int    m_wcnt = 0;

  task automatic fifo_drive();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? '0 : fifo_q[0];
  endtask

  // Push into the FIFO model and predict the four lanes plus frame marker.
  task automatic push_word(input word_t w);
    int eff;
    if (fifo_q.size() < DEPTH) fifo_q.push_back(w);
    fifo_drive();
    eff = (cfg == '0) ? 1 : int'(cfg);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back('{w[k*16 +: 16], (k == 3) && (m_wcnt == eff - 1)});
    end
    m_wcnt = (m_wcnt == eff - 1) ? 0 : m_wcnt + 1;
  endtask

  // One clock: record any lane transfer, then apply the FIFO pop after the edge.
  task automatic tick();
    logic pop;
    #1;
    if (rst_n && out_valid && out_ready)
      obs_q.push_back('{out_data, out_last, fifo_r_ready, cycle});
    pop = fifo_r_ready;
    @(posedge clk);
    #1;
    cycle++;
    if (pop && rst_n && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_drive();
  endtask

  task automatic collect(input int n);
    for (int i = 0; i < 400 && obs_q.size() < n; i++) tick();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_last, out_data, fifo_r_ready, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b last=%b data=%h rready=%b busy=%b, required all 0",
               out_valid, out_last, out_data, fifo_r_ready, busy);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_word();
    int c0;
    obs_t o;
    exp_t e;
    cfg = 16'd1;
    out_ready = 1'b1;
    c0 = cycle;
    push_word(64'h0004_0003_0002_0001);
    collect(4);
    checks++;
    if (obs_q.size() < 4) begin
      errors++;
      $display("FAIL single_timeout: got %0d lanes, required 4", obs_q.size());
    end
    for (int i = 0; i < 4 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.last !== e.last || o.cyc !== c0 + 1 + i) begin
        errors++;
        $display("FAIL single_lane%0d: data=%h last=%b cyc=%0d, required data=%h last=%b cyc=%0d",
                 i, o.data, o.last, o.cyc, e.data, e.last, c0 + 1 + i);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int c0;
    obs_t o;
    exp_t e;
    cfg = 16'd1;
    out_ready = 1'b1;
    push_word(64'h1113_1112_1111_1110);
    push_word(64'h2223_2222_2221_2220);
    push_word(64'h3333_3332_3331_3330);
    collect(12);
    checks++;
    if (obs_q.size() < 12) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d lanes, required 12", obs_q.size());
    end
    c0 = (obs_q.size() > 0) ? obs_q[0].cyc : 0;
    for (int i = 0; i < 12 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.last !== e.last || o.cyc !== c0 + i ||
          o.popped !== ((i % 4 == 3) && (i < 11))) begin
        errors++;
        $display("FAIL b2b_lane%0d: data=%h last=%b cyc=%0d pop=%b, required data=%h last=%b cyc=%0d pop=%b",
                 i, o.data, o.last, o.cyc, o.popped, e.data, e.last, c0 + i,
                 (i % 4 == 3) && (i < 11));
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    obs_t o;
    exp_t e;
    cfg = 16'd1;
    out_ready = 1'b0;
    push_word(64'h0004_0003_0002_0001);
    push_word(64'h0008_0007_0006_0005);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h0002 || fifo_r_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_cycle%0d: valid=%b data=%h rready=%b, required valid=1 data=0002 rready=0",
                 i, out_valid, out_data, fifo_r_ready);
      end
    end
    out_ready = 1'b1;
    collect(8);
    checks++;
    if (obs_q.size() < 8) begin
      errors++;
      $display("FAIL stall_timeout: got %0d lanes, required 8", obs_q.size());
    end
    for (int i = 0; i < 8 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.last !== e.last) begin
        errors++;
        $display("FAIL stall_lane%0d: data=%h last=%b, required data=%h last=%b",
                 i, o.data, o.last, e.data, e.last);
      end
    end
    tick();
  endtask

  task automatic test_frame();
    obs_t o;
    exp_t e;
    cfg = 16'd2;
    out_ready = 1'b1;
    for (int w = 0; w < 4; w++) push_word({16'hA000 + 16'(w*4+3), 16'hA000 + 16'(w*4+2),
                                          16'hA000 + 16'(w*4+1), 16'hA000 + 16'(w*4)});
    collect(16);
    checks++;
    if (obs_q.size() < 16) begin
      errors++;
      $display("FAIL frame_timeout: got %0d lanes, required 16", obs_q.size());
    end
    for (int i = 0; i < 16 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.last !== e.last || o.last !== (i == 7 || i == 15)) begin
        errors++;
        $display("FAIL frame_lane%0d: data=%h last=%b, required data=%h last=%b",
                 i, o.data, o.last, e.data, e.last);
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL frame_idle: busy=%b valid=%b, required 0 0", busy, out_valid);
    end
  endtask

  task automatic test_starve();
    obs_t o;
    exp_t e;
    cfg = 16'd1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (fifo_r_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL empty_cycle%0d: rready=%b valid=%b, required 0 0", i, fifo_r_ready, out_valid);
      end
    end
    cfg = 16'd3;
    push_word(64'hB003_B002_B001_B000);
    push_word(64'hB013_B012_B011_B010);
    collect(8);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL starve_cycle%0d: busy=%b valid=%b, required busy=1 valid=0", i, busy, out_valid);
      end
    end
    push_word(64'hB023_B022_B021_B020);
    collect(12);
    checks++;
    if (obs_q.size() < 12) begin
      errors++;
      $display("FAIL starve_timeout: got %0d lanes, required 12", obs_q.size());
    end
    for (int i = 0; i < 12 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.last !== e.last || o.last !== (i == 11)) begin
        errors++;
        $display("FAIL starve_lane%0d: data=%h last=%b, required data=%h last=%b",
                 i, o.data, o.last, e.data, e.last);
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL starve_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_reset_mid_word();
    obs_t o;
    exp_t e;
    cfg = 16'd2;
    out_ready = 1'b1;
    push_word(64'hC003_C002_C001_C000);
    push_word(64'hC013_C012_C011_C010);
    collect(6);
    for (int i = 0; i < 6 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.last !== e.last) begin
        errors++;
        $display("FAIL prereset_lane%0d: data=%h last=%b, required data=%h last=%b",
                 i, o.data, o.last, e.data, e.last);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_last, out_data, fifo_r_ready, busy} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: valid=%b last=%b data=%h rready=%b busy=%b, required all 0",
               out_valid, out_last, out_data, fifo_r_ready, busy);
    end
    exp_q.delete();
    obs_q.delete();
    fifo_q.delete();
    m_wcnt = 0;
    fifo_drive();
    tick();
    rst_n = 1'b1;
    push_word(64'hD003_D002_D001_D000);
    push_word(64'hD013_D012_D011_D010);
    collect(8);
    checks++;
    if (obs_q.size() < 8) begin
      errors++;
      $display("FAIL postreset_timeout: got %0d lanes, required 8", obs_q.size());
    end
    for (int i = 0; i < 8 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o.data !== e.data || o.last !== e.last || o.last !== (i == 7)) begin
        errors++;
        $display("FAIL postreset_lane%0d: data=%h last=%b, required data=%h last=%b",
                 i, o.data, o.last, e.data, e.last);
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_frame();
    test_starve();
    test_reset_mid_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_unpacker.md
Name: fifo_unpacker

Overview:
Downstream consumer of the 64-bit sync FIFO (fifo_empty / r_ready / data_out interface). It pops one wide word at a time and serialises it into narrower lanes on a valid/ready stream, LSB lane first. It also marks frame boundaries with out_last, using a runtime word count per frame. It sits between the FIFO read port and the compute datapath that consumes OUT_WIDTH-bit elements.

Parameters:
IN_WIDTH, 64, FIFO word width; must be an integer multiple of OUT_WIDTH.
OUT_WIDTH, 16, output lane width.
LANES, IN_WIDTH/OUT_WIDTH (derived localparam), lanes per word; 1 is legal (pass-through).
FRAME_CNT_W, 16, width of the frame word counter and cfg_frame_words.

Ports:
clk  input  1  clock.
rst_n  input  1  reset, asynchronous, active-low.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  IN_WIDTH  FIFO head word; first-word fall-through, valid whenever fifo_empty=0.
fifo_r_ready  output  1  pop strobe; the FIFO advances on a posedge where this is 1.
out_valid  output  1  lane valid.
out_ready  input  1  downstream accepts lane.
out_data  output  OUT_WIDTH  current lane.
out_last  output  1  final lane of the final word of a frame.
cfg_frame_words  input  FRAME_CNT_W  words per frame; 0 is treated as 1.
busy  output  1  word held or frame in progress (word_cnt != 0).

Behaviour:
- State: EMPTY (no word held), HOLD (word in data_q). Registers: data_q[IN_WIDTH], lane_idx[clog2(LANES) or 1], word_cnt, frame_len_q.
- Reset (async): state=EMPTY, data_q=0, lane_idx=0, word_cnt=0, frame_len_q=1. All outputs 0.
- lane_xfer = out_valid && out_ready; word_done = lane_xfer && lane_idx==LANES-1.
- fifo_r_ready (combinational) = !fifo_empty && (state==EMPTY || word_done). It is never 1 while fifo_empty=1.
- Pop edge: data_q <= fifo_data, lane_idx <= 0, state <= HOLD.
- word_done without a pop: state <= EMPTY.
- lane_xfer and !word_done: lane_idx <= lane_idx+1.
- out_valid = (state==HOLD). out_data = data_q[lane_idx*OUT_WIDTH +: OUT_WIDTH].
- Latency: fifo_empty falls in cycle N while EMPTY -> pop at the end of N -> out_valid=1 in N+1.
- Throughput: with out_ready=1 and the FIFO non-empty, the next word is popped in the same cycle as word_done. No bubble; one lane per cycle sustained.
- Backpressure: while out_valid && !out_ready, out_data, out_last, lane_idx and data_q hold stable. out_valid never drops without a transfer.
- Frame: when a word is popped with word_cnt==0, frame_len_q <= max(cfg_frame_words,1). cfg changes mid-frame have no effect.
- out_last = out_valid && lane_idx==LANES-1 && word_cnt==frame_len_q-1.
- On word_done: word_cnt <= (word_cnt==frame_len_q-1) ? 0 : word_cnt+1.
- busy = (state==HOLD) || (word_cnt!=0).
- FIFO empty at word_done: out_valid=0 next cycle. The frame stays open (word_cnt retained) until further words arrive.
- LANES==1: lane_idx is fixed at 0 and every lane_xfer is a word_done.
- Reset mid-word: the held word and partial frame are discarded. Words already popped are not recovered.
- Lane order is LSB-first: lane k = bits [k*OUT_WIDTH +: OUT_WIDTH].

Decomposition:
- Shared package fifo_pkg: IN_WIDTH/OUT_WIDTH defaults (64/16), typedef word_t (logic [63:0]), typedef lane_t (logic [15:0]).
- Single module, no sub-module. The lane mux is an indexed part-select. The frame counter is small enough to stay inline.
- Bench instantiates fifo (DEPTH=4) feeding fifo_unpacker.

Test Plan:
1. Push 64'h0004_0003_0002_0001, cfg=1, out_ready=1 -> out_data 0001,0002,0003,0004 on 4 consecutive cycles starting 1 cycle after fifo_empty falls; out_last=1 only with 0004.
2. Push 3 words back-to-back, out_ready=1 -> 12 consecutive out_valid cycles with no gap; fifo_r_ready pulses coincide with lane 3 transfers.
3. out_ready=0 for 5 cycles while lane 0002 is shown -> out_data=0002 and out_valid=1 stable throughout; no pop occurs; resumes with 0003.
4. cfg=2, push 4 words -> out_last asserts on the 8th and 16th lanes only; busy=0 after the 16th.
5. FIFO empty for 20 cycles -> fifo_r_ready=0, out_valid=0. Then starve mid-frame (cfg=3, only 2 words) -> busy stays 1, and out_last appears on the 3rd word when it arrives.
6. Assert rst_n=0 after lane 1 of a word -> all outputs 0 immediately; the next pushed word emits from lane 0 with word_cnt=0.
